// File: rtl/spatz_vlsu_agen.sv
// Vector load/store address generator: spreads the elements of one memory command
// round-robin over NrMemPorts request ports, throttles each port with a credit
// counter and pulses done_o once every issued request has been answered.
module spatz_vlsu_agen #(
    parameter int unsigned NrMemPorts    = 2,
    parameter int unsigned NrOutstanding = 8,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned VlWidth       = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    // Command
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic [AddrWidth-1:0]            cmd_base_i,
    input  logic [AddrWidth-1:0]            cmd_stride_i,
    input  logic                            cmd_strided_i,
    input  logic [1:0]                      cmd_vsew_i,
    input  logic [VlWidth-1:0]              cmd_vl_i,
    // Per-port memory requests
    output logic [NrMemPorts-1:0]           req_valid_o,
    input  logic [NrMemPorts-1:0]           req_ready_i,
    output logic [NrMemPorts*AddrWidth-1:0] req_addr_o,
    output logic [NrMemPorts*4-1:0]         req_strb_o,
    output logic [NrMemPorts*VlWidth-1:0]   req_elem_o,
    output logic [NrMemPorts-1:0]           req_last_o,
    // Per-port responses
    input  logic [NrMemPorts-1:0]           rsp_valid_i,
    // Status
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            misaligned_o
);

    localparam int unsigned CredWidth = $clog2(NrOutstanding + 1);
    localparam logic [CredWidth-1:0] CredMax  = CredWidth'(NrOutstanding);
    localparam logic [AddrWidth-1:0] PortsA   = AddrWidth'(NrMemPorts);
    localparam logic [VlWidth-1:0]   PortsV   = VlWidth'(NrMemPorts);
    localparam logic [VlWidth:0]     PortsL   = (VlWidth+1)'(NrMemPorts);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                  state_q, state_d;
    logic [AddrWidth-1:0]    step_q, step_d;
    logic [1:0]              vsew_q, vsew_d;
    logic [VlWidth-1:0]      vl_q, vl_d;
    logic [AddrWidth-1:0]    addr_q [NrMemPorts];
    logic [AddrWidth-1:0]    addr_d [NrMemPorts];
    logic [VlWidth-1:0]      elem_q [NrMemPorts];
    logic [VlWidth-1:0]      elem_d [NrMemPorts];
    logic [CredWidth-1:0]    cred_q [NrMemPorts];
    logic [CredWidth-1:0]    cred_d [NrMemPorts];
    logic [NrMemPorts-1:0]   work_q, work_d;
    logic [NrMemPorts-1:0]   valid_q, valid_d;
    logic                    done_q, done_d;
    logic                    mis_q, mis_d;

    logic [NrMemPorts-1:0]   req_hs;
    logic [NrMemPorts-1:0]   last;
    logic [NrMemPorts-1:0]   port_mis;
    logic [NrMemPorts-1:0]   cred_full;

    assign req_hs = valid_q & req_ready_i;

    // Request payload decoded from the per-port unaligned address and element index.
    always_comb begin
        req_addr_o = '0;
        req_strb_o = '0;
        req_elem_o = '0;
        last       = '0;
        port_mis   = '0;
        cred_full  = '0;
        for (int p = 0; p < NrMemPorts; p++) begin
            req_addr_o[p*AddrWidth +: AddrWidth] = {addr_q[p][AddrWidth-1:2], 2'b00};
            req_elem_o[p*VlWidth +: VlWidth]     = elem_q[p];
            case (vsew_q)
                2'd0:    req_strb_o[p*4 +: 4] = 4'b0001 << addr_q[p][1:0];
                2'd1:    req_strb_o[p*4 +: 4] = addr_q[p][1] ? 4'b1100 : 4'b0011;
                default: req_strb_o[p*4 +: 4] = 4'b1111;
            endcase
            // Extra MSB keeps elem + NrMemPorts from wrapping near the top of the range.
            last[p]      = ({1'b0, elem_q[p]} + PortsL) >= {1'b0, vl_q};
            port_mis[p]  = ((vsew_q == 2'd1) && addr_q[p][0]) ||
                           ((vsew_q == 2'd2) && (addr_q[p][1:0] != 2'b00));
            cred_full[p] = (cred_q[p] == CredMax);
        end
    end

    assign req_valid_o  = valid_q;
    assign req_last_o   = last;
    assign cmd_ready_o  = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign done_o       = done_q;
    assign misaligned_o = mis_q;

    // Next-state: credits, command acceptance, per-port advance and completion.
    always_comb begin
        logic all_full;
        state_d  = state_q;
        step_d   = step_q;
        vsew_d   = vsew_q;
        vl_d     = vl_q;
        work_d   = work_q;
        done_d   = 1'b0;
        mis_d    = mis_q;
        valid_d  = '0;
        all_full = 1'b1;
        for (int p = 0; p < NrMemPorts; p++) begin
            addr_d[p] = addr_q[p];
            elem_d[p] = elem_q[p];
            cred_d[p] = cred_q[p];
            // A handshake and a response in the same cycle cancel out.
            case ({req_hs[p], rsp_valid_i[p]})
                2'b10:   cred_d[p] = cred_q[p] - CredWidth'(1);
                2'b01:   if (cred_q[p] != CredMax) cred_d[p] = cred_q[p] + CredWidth'(1);
                default: cred_d[p] = cred_q[p];
            endcase
            if (cred_d[p] != CredMax) all_full = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    mis_d  = 1'b0;
                    vsew_d = cmd_vsew_i;
                    vl_d   = cmd_vl_i;
                    step_d = cmd_strided_i ? cmd_stride_i : (AddrWidth'(1) << cmd_vsew_i);
                    // Empty or illegal-width commands complete without touching memory.
                    if (cmd_vl_i == '0 || cmd_vsew_i == 2'd3) begin
                        done_d = 1'b1;
                        work_d = '0;
                    end else begin
                        state_d = StIssue;
                        for (int p = 0; p < NrMemPorts; p++) begin
                            addr_d[p] = cmd_base_i + AddrWidth'(p) * step_d;
                            elem_d[p] = VlWidth'(p);
                            work_d[p] = (VlWidth+1)'(p) < {1'b0, cmd_vl_i};
                        end
                    end
                end
            end
            StIssue: begin
                for (int p = 0; p < NrMemPorts; p++) begin
                    if (req_hs[p]) begin
                        addr_d[p] = addr_q[p] + PortsA * step_q;
                        elem_d[p] = elem_q[p] + PortsV;
                        if (last[p])     work_d[p] = 1'b0;
                        if (port_mis[p]) mis_d     = 1'b1;
                    end
                end
                if (work_d == '0) state_d = StDrain;
            end
            StDrain: begin
                if (all_full) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        for (int p = 0; p < NrMemPorts; p++) begin
            valid_d[p] = (state_d == StIssue) && work_d[p] && (cred_d[p] != '0);
        end
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            step_q  <= '0;
            vsew_q  <= '0;
            vl_q    <= '0;
            work_q  <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            for (int p = 0; p < NrMemPorts; p++) begin
                addr_q[p] <= '0;
                elem_q[p] <= '0;
                cred_q[p] <= CredMax;
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            vsew_q  <= vsew_d;
            vl_q    <= vl_d;
            work_q  <= work_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            for (int p = 0; p < NrMemPorts; p++) begin
                addr_q[p] <= addr_d[p];
                elem_q[p] <= elem_d[p];
                cred_q[p] <= cred_d[p];
            end
        end
    end

    // While a command is in flight every response must match a request. In IDLE,
    // responses orphaned by a reset are expected and silently dropped.
    excess_rsp_a : assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q != StIdle) |-> ((rsp_valid_i & ~req_hs & cred_full) == '0))
        else $error("excess response on a port whose credits are already full");

endmodule

// File: tb/tb_spatz_vlsu_agen.sv
// Bench for spatz_vlsu_agen: element-level reference model (element i -> port i % P,
// address base + i*stride) with per-port outstanding counts, checked every cycle.
module tb_spatz_vlsu_agen;
    localparam int P  = 2;
    localparam int NO = 2;
    localparam int AW = 32;
    localparam int VW = 16;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            cmd_valid_i = 1'b0;
    logic            cmd_ready_o;
    logic [AW-1:0]   cmd_base_i = '0;
    logic [AW-1:0]   cmd_stride_i = '0;
    logic            cmd_strided_i = 1'b0;
    logic [1:0]      cmd_vsew_i = '0;
    logic [VW-1:0]   cmd_vl_i = '0;
    logic [P-1:0]    req_valid_o;
    logic [P-1:0]    req_ready_i = '0;
    logic [P*AW-1:0] req_addr_o;
    logic [P*4-1:0]  req_strb_o;
    logic [P*VW-1:0] req_elem_o;
    logic [P-1:0]    req_last_o;
    logic [P-1:0]    rsp_valid_i = '0;
    logic            busy_o, done_o, misaligned_o;

    always #5 clk = ~clk;

    spatz_vlsu_agen #(
        .NrMemPorts(P), .NrOutstanding(NO), .AddrWidth(AW), .VlWidth(VW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_base_i(cmd_base_i), .cmd_stride_i(cmd_stride_i),
        .cmd_strided_i(cmd_strided_i), .cmd_vsew_i(cmd_vsew_i), .cmd_vl_i(cmd_vl_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_addr_o(req_addr_o), .req_strb_o(req_strb_o),
        .req_elem_o(req_elem_o), .req_last_o(req_last_o),
        .rsp_valid_i(rsp_valid_i),
        .busy_o(busy_o), .done_o(done_o), .misaligned_o(misaligned_o)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    strb;
        logic [VW-1:0] elem;
        logic          last;
        logic          mis;
    } req_t;

    req_t exp_q [P][$];
    req_t log_q [P][$];
    int   due_q [P][$];
    int   out_cnt [P];
    int   last_due [P];
    int   release_cnt [P];
    bit   active, exp_done, exp_mis;
    int   cyc, tests, fails, done_cnt;
    bit   ready_rand;
    int   lat_min, lat_max;
    logic [P-1:0] hold;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit pending();
        for (int p = 0; p < P; p++) if (due_q[p].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Expand the accepted command into the per-port element lists.
    task automatic load_cmd();
        logic [AW-1:0] step, a;
        req_t e;
        step = cmd_strided_i ? cmd_stride_i : (32'd1 << cmd_vsew_i);
        for (int i = 0; i < int'(cmd_vl_i); i++) begin
            a = cmd_base_i + 32'(i) * step;
            e.addr = {a[AW-1:2], 2'b00};
            case (cmd_vsew_i)
                2'd0:    e.strb = 4'b0001 << a[1:0];
                2'd1:    e.strb = (a[1:0] >= 2) ? 4'b1100 : 4'b0011;
                default: e.strb = 4'b1111;
            endcase
            e.elem = VW'(i);
            e.last = (i + P >= int'(cmd_vl_i));
            e.mis  = (cmd_vsew_i == 2'd1 && a[0]) || (cmd_vsew_i == 2'd2 && a[1:0] != 0);
            exp_q[i % P].push_back(e);
        end
    endtask

    // Per-cycle compare, response/ready driving and model update.
    always @(negedge clk) begin : model
        logic [P-1:0] ev;
        logic         all_done;
        req_t         e, g;
        int           d;
        cyc++;
        for (int p = 0; p < P; p++) begin
            ev[p] = active && exp_q[p].size() > 0 && out_cnt[p] < NO;
            chk($sformatf("p%0d.valid", p), 64'(req_valid_o[p]), 64'(ev[p]));
            if (ev[p]) begin
                e = exp_q[p][0];
                chk($sformatf("p%0d.addr", p), 64'(req_addr_o[p*AW +: AW]), 64'(e.addr));
                chk($sformatf("p%0d.strb", p), 64'(req_strb_o[p*4 +: 4]), 64'(e.strb));
                chk($sformatf("p%0d.elem", p), 64'(req_elem_o[p*VW +: VW]), 64'(e.elem));
                chk($sformatf("p%0d.last", p), 64'(req_last_o[p]), 64'(e.last));
            end
        end
        chk("cmd_ready", 64'(cmd_ready_o), 64'(!active));
        chk("busy", 64'(busy_o), 64'(active));
        chk("done", 64'(done_o), 64'(exp_done));
        chk("misaligned", 64'(misaligned_o), 64'(exp_mis));
        if (done_o) done_cnt++;

        for (int p = 0; p < P; p++) begin
            req_ready_i[p] = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            rsp_valid_i[p] = 1'b0;
            if (due_q[p].size() > 0 && due_q[p][0] <= cyc && (!hold[p] || release_cnt[p] > 0)) begin
                rsp_valid_i[p] = 1'b1;
                void'(due_q[p].pop_front());
                if (hold[p]) release_cnt[p]--;
            end
        end

        if (rst_i) begin
            active = 1'b0; exp_done = 1'b0; exp_mis = 1'b0;
            for (int p = 0; p < P; p++) begin
                exp_q[p].delete();
                out_cnt[p] = 0;
            end
        end else begin
            exp_done = 1'b0;
            for (int p = 0; p < P; p++) begin
                if (ev[p] && req_ready_i[p]) begin
                    e = exp_q[p].pop_front();
                    g.addr = req_addr_o[p*AW +: AW];
                    g.strb = req_strb_o[p*4 +: 4];
                    g.elem = req_elem_o[p*VW +: VW];
                    g.last = req_last_o[p];
                    g.mis  = 1'b0;
                    log_q[p].push_back(g);
                    if (e.mis) exp_mis = 1'b1;
                    out_cnt[p]++;
                    d = cyc + $urandom_range(lat_min, lat_max);
                    if (d < last_due[p]) d = last_due[p];
                    last_due[p] = d;
                    due_q[p].push_back(d);
                end
                if (rsp_valid_i[p]) out_cnt[p] = (out_cnt[p] > 0) ? out_cnt[p] - 1 : 0;
            end
            if (cmd_valid_i && !active) begin
                exp_mis = 1'b0;
                if (cmd_vl_i == 0 || cmd_vsew_i == 2'd3) exp_done = 1'b1;
                else begin
                    load_cmd();
                    active = 1'b1;
                end
            end else if (active) begin
                all_done = 1'b1;
                for (int p = 0; p < P; p++)
                    if (exp_q[p].size() != 0 || out_cnt[p] != 0) all_done = 1'b0;
                if (all_done) begin
                    active   = 1'b0;
                    exp_done = 1'b1;
                end
            end
        end
    end

    task automatic issue_cmd(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                             input logic strided, input logic [1:0] vsew,
                             input logic [VW-1:0] vl);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!cmd_ready_o && n < 2000) begin @(posedge clk); #1; n++; end
        if (n >= 2000) chk("cmd_ready_timeout", 64'(cmd_ready_o), 64'd1);
        cmd_base_i = base; cmd_stride_i = stride; cmd_strided_i = strided;
        cmd_vsew_i = vsew; cmd_vl_i = vl; cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((active || exp_done || pending()) && n < 3000) begin @(posedge clk); #1; n++; end
        if (n >= 3000) chk("idle_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        for (int p = 0; p < P; p++) log_q[p].delete();
    endtask

    task automatic chk_log(input int p, input int idx, input logic [AW-1:0] addr,
                           input logic [3:0] strb, input logic [VW-1:0] elem, input logic last);
        if (idx >= log_q[p].size()) chk($sformatf("log%0d.len", p), 64'(log_q[p].size()), 64'(idx + 1));
        else begin
            chk($sformatf("log%0d[%0d].addr", p, idx), 64'(log_q[p][idx].addr), 64'(addr));
            chk($sformatf("log%0d[%0d].strb", p, idx), 64'(log_q[p][idx].strb), 64'(strb));
            chk($sformatf("log%0d[%0d].elem", p, idx), 64'(log_q[p][idx].elem), 64'(elem));
            chk($sformatf("log%0d[%0d].last", p, idx), 64'(log_q[p][idx].last), 64'(last));
        end
    endtask

    initial begin
        int d0;
        ready_rand = 1'b0; lat_min = 2; lat_max = 2; hold = '0;
        for (int p = 0; p < P; p++) release_cnt[p] = 0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        // Unit-stride 32-bit, five elements over two ports.
        clear_logs(); d0 = done_cnt;
        issue_cmd(32'h1000, 32'h0, 1'b0, 2'd2, 16'd5);
        wait_idle();
        chk_log(0, 0, 32'h1000, 4'hF, 16'd0, 1'b0);
        chk_log(0, 1, 32'h1008, 4'hF, 16'd2, 1'b0);
        chk_log(0, 2, 32'h1010, 4'hF, 16'd4, 1'b1);
        chk_log(1, 0, 32'h1004, 4'hF, 16'd1, 1'b0);
        chk_log(1, 1, 32'h100C, 4'hF, 16'd3, 1'b1);
        chk("t1.done_pulses", 64'(done_cnt - d0), 64'd1);

        // Negative stride, 16-bit elements.
        clear_logs();
        issue_cmd(32'h200, 32'hFFFF_FFFA, 1'b1, 2'd1, 16'd3);
        wait_idle();
        chk_log(0, 0, 32'h200, 4'b0011, 16'd0, 1'b0);
        chk_log(0, 1, 32'h1F4, 4'b0011, 16'd2, 1'b1);
        chk_log(1, 0, 32'h1F8, 4'b1100, 16'd1, 1'b1);
        chk("t2.misaligned", 64'(misaligned_o), 64'd0);

        // Credit exhaustion with responses withheld, then a single response on port 0.
        clear_logs(); hold = '1;
        issue_cmd(32'h0, 32'h0, 1'b0, 2'd2, 16'd8);
        repeat (6) begin @(posedge clk); #1; end
        chk("t3.valid_stalled", 64'(req_valid_o), 64'd0);
        chk("t3.p0_issued", 64'(log_q[0].size()), 64'd2);
        chk("t3.p1_issued", 64'(log_q[1].size()), 64'd2);
        release_cnt[0] = 1;
        @(posedge clk); #1;
        chk("t3.p0_resumed", 64'(req_valid_o), 64'b01);
        chk("t3.p0_elem", 64'(req_elem_o[VW-1:0]), 64'd4);
        hold = '0;
        wait_idle();
        chk_log(0, 3, 32'h18, 4'hF, 16'd6, 1'b1);

        // Zero-length command.
        clear_logs(); d0 = done_cnt;
        issue_cmd(32'h40, 32'h0, 1'b0, 2'd0, 16'd0);
        chk("t4.done", 64'(done_o), 64'd1);
        chk("t4.cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("t4.valid", 64'(req_valid_o), 64'd0);
        wait_idle();
        chk("t4.no_requests", 64'(log_q[0].size() + log_q[1].size()), 64'd0);
        chk("t4.done_pulses", 64'(done_cnt - d0), 64'd1);

        // Misaligned word access, then cleared by the next command.
        clear_logs();
        issue_cmd(32'h1002, 32'h0, 1'b0, 2'd2, 16'd1);
        wait_idle();
        chk_log(0, 0, 32'h1000, 4'hF, 16'd0, 1'b1);
        chk("t5.misaligned_set", 64'(misaligned_o), 64'd1);
        issue_cmd(32'h0, 32'h0, 1'b0, 2'd3, 16'd4);
        chk("t5.misaligned_clr", 64'(misaligned_o), 64'd0);
        chk("t5.vsew3_done", 64'(done_o), 64'd1);
        wait_idle();

        // Reset in the middle of issue; late responses must be ignored.
        hold = '1;
        issue_cmd(32'h3000, 32'h0, 1'b0, 2'd2, 16'd20);
        repeat (2) begin @(posedge clk); #1; end
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk("t6.valid", 64'(req_valid_o), 64'd0);
        chk("t6.busy", 64'(busy_o), 64'd0);
        chk("t6.cmd_ready", 64'(cmd_ready_o), 64'd1);
        hold = '0;
        wait_idle();
        chk("t6.busy_after_rsp", 64'(busy_o), 64'd0);
        clear_logs(); hold = '1;
        issue_cmd(32'h0, 32'h0, 1'b0, 2'd0, 16'd8);
        repeat (5) begin @(posedge clk); #1; end
        chk("t6.p0_full_credits", 64'(log_q[0].size()), 64'(NO));
        chk("t6.p1_full_credits", 64'(log_q[1].size()), 64'(NO));
        hold = '0;
        wait_idle();

        // Random commands, back-to-back, random ready and response latency.
        ready_rand = 1'b1; lat_min = 1; lat_max = 5;
        for (int k = 0; k < 40; k++) begin
            logic [AW-1:0] stride;
            stride = ($urandom_range(0, 3) == 0) ? AW'($urandom)
                                                 : AW'($urandom_range(0, 40)) - 32'd20;
            issue_cmd(AW'($urandom), stride, 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), VW'($urandom_range(0, 17)));
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
